// File: rtl/bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter feeding a four-digit display driver.
// Optional build macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits (code 4'hF).
module bcd_converter #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic             overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BCD   = BIN_W'(9999);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t                 state;
  logic [15:0]            scratch;
  logic [BIN_W-1:0]       shift;
  logic [CNT_W-1:0]       cnt;
  logic                   ovf_pending;

  logic [15:0]            adjusted;
  logic [16+BIN_W-1:0]    shifted;
  logic [15:0]            result;

  // Add 3 to every nibble that is 5 or more, all four in parallel.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Blank zeros from the thousands digit down; the ones digit always shows.
  function automatic logic [15:0] blank_leading(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (d[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (d[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (d[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
    return r;
  endfunction
`endif

  always_comb begin
    adjusted = dabble_adjust(scratch);
    shifted  = {adjusted, shift} << 1;
    if (ovf_pending) begin
      result = 16'hFFFF;
    end else begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
      result = blank_leading(scratch);
`else
      result = scratch;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      digit0      <= 4'h0;
      digit1      <= 4'h0;
      digit2      <= 4'h0;
      digit3      <= 4'h0;
      scratch     <= '0;
      shift       <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift       <= bin_in;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= (bin_in > MAX_BCD);
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[16+BIN_W-1:BIN_W];
          shift   <= shifted[BIN_W-1:0];
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= FINISH;
        end
        FINISH: begin
          // Digits only change here so the display never shows partial results.
          done     <= 1'b1;
          busy     <= 1'b0;
          digit3   <= result[15:12];
          digit2   <= result[11:8];
          digit1   <= result[7:4];
          digit0   <= result[3:0];
          overflow <= ovf_pending;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed-vector bench for bcd_converter (BIN_W = 14); honours BCD_LEADING_ZERO_BLANK_EN.
module tb_bcd_converter;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             busy, done, overflow;
  logic [3:0]       digit0, digit1, digit2, digit3;

  int n_vec = 0;
  int n_err = 0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [15:0] EXP_0   = 16'hFFF0;
  localparam logic [15:0] EXP_5   = 16'hFFF5;
  localparam logic [15:0] EXP_42  = 16'hFF42;
  localparam logic [15:0] EXP_321 = 16'hF321;
`else
  localparam logic [15:0] EXP_0   = 16'h0000;
  localparam logic [15:0] EXP_5   = 16'h0005;
  localparam logic [15:0] EXP_42  = 16'h0042;
  localparam logic [15:0] EXP_321 = 16'h0321;
`endif

  bcd_converter #(.BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Stimulus only: issue one load and wait (bounded) for done. Called at #1 after an edge.
  task automatic run_conv(input logic [BIN_W-1:0] v, output int lat, output int busy_cnt,
                          output logic [15:0] dig, output logic ovf);
    bin_in = v;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load     = 1'b0;
    bin_in   = ~v;
    lat      = -1;
    busy_cnt = busy ? 1 : 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        break;
      end
    end
    dig = {digit3, digit2, digit1, digit0};
    ovf = overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, overflow} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: busy/done/ovf=%b required 000", {busy, done, overflow});
    end
    n_vec++;
    if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_digits: got %h required 0000", {digit3, digit2, digit1, digit0});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [15:0] dig;
    logic ovf;
    run_conv(14'd1234, lat, bc, dig, ovf);
    n_vec++;
    if (lat !== 15) begin n_err++; $display("FAIL basic_latency: got %0d required 15", lat); end
    n_vec++;
    if (bc !== 15) begin n_err++; $display("FAIL basic_busy_cycles: got %0d required 15", bc); end
    n_vec++;
    if (dig !== 16'h1234) begin n_err++; $display("FAIL basic_digits: got %h required 1234", dig); end
    n_vec++;
    if (ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b required 0", ovf); end
    @(posedge clk);
    #1;
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [15:0] dig;
    logic ovf;
    run_conv(14'd9999, lat, bc, dig, ovf);
    n_vec++;
    if (dig !== 16'h9999 || ovf !== 1'b0) begin
      n_err++; $display("FAIL b2b_9999: got %h ovf %b required 9999 ovf 0", dig, ovf);
    end
    run_conv(14'd0, lat, bc, dig, ovf);
    n_vec++;
    if (lat !== 15) begin n_err++; $display("FAIL b2b_latency: got %0d required 15", lat); end
    n_vec++;
    if (dig !== EXP_0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL b2b_zero: got %h ovf %b required %h ovf 0", dig, ovf, EXP_0);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [15:0] dig;
    logic ovf;
    run_conv(14'd10000, lat, bc, dig, ovf);
    n_vec++;
    if (dig !== 16'hFFFF || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_10000: got %h ovf %b required ffff ovf 1", dig, ovf);
    end
    run_conv(14'd16383, lat, bc, dig, ovf);
    n_vec++;
    if (dig !== 16'hFFFF || ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_16383: got %h ovf %b required ffff ovf 1", dig, ovf);
    end
    run_conv(14'd5, lat, bc, dig, ovf);
    n_vec++;
    if (dig !== EXP_5 || ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear_5: got %h ovf %b required %h ovf 0", dig, ovf, EXP_5);
    end
  endtask

  task automatic test_ignored_load();
    int done_cnt;
    int lat, bc;
    logic [15:0] dig, first_dig;
    logic ovf;
    done_cnt  = 0;
    first_dig = 16'h0000;
    bin_in = 14'd42;
    load   = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 40; c++) begin
      load   = (c == 3 || c == 15);
      bin_in = load ? 14'd7777 : 14'd42;
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_dig = {digit3, digit2, digit1, digit0};
      end
    end
    load = 1'b0;
    n_vec++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d required 1", done_cnt); end
    n_vec++;
    if (first_dig !== EXP_42) begin
      n_err++; $display("FAIL ign_digits: got %h required %h", first_dig, EXP_42);
    end
    run_conv(14'd7777, lat, bc, dig, ovf);
    n_vec++;
    if (lat !== 15 || dig !== 16'h7777) begin
      n_err++; $display("FAIL ign_next_load: lat %0d digits %h required 15 7777", lat, dig);
    end
  endtask

  task automatic test_abort();
    int lat, bc, done_cnt;
    logic [15:0] dig;
    logic ovf;
    done_cnt = 0;
    bin_in = 14'd5678;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({busy, done, overflow} !== 3'b000) begin
      n_err++; $display("FAIL abort_ctrl: busy/done/ovf=%b required 000", {busy, done, overflow});
    end
    n_vec++;
    if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
      n_err++; $display("FAIL abort_digits: got %h required 0000", {digit3, digit2, digit1, digit0});
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    n_vec++;
    if (done_cnt !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt); end
    run_conv(14'd321, lat, bc, dig, ovf);
    n_vec++;
    if (dig !== EXP_321 || ovf !== 1'b0) begin
      n_err++; $display("FAIL abort_next_321: got %h ovf %b required %h ovf 0", dig, ovf, EXP_321);
    end
  endtask

  task automatic test_hold();
    int lat, bc;
    logic [15:0] dig;
    logic ovf;
    run_conv(14'd8605, lat, bc, dig, ovf);
    n_vec++;
    if (dig !== 16'h8605) begin n_err++; $display("FAIL hold_setup: got %h required 8605", dig); end
    for (int c = 0; c < 100; c++) begin
      bin_in = 14'(c * 97);
      @(posedge clk);
      #1;
      n_vec++;
      if ({digit3, digit2, digit1, digit0, overflow, done} !== {16'h8605, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: digits %h ovf %b done %b required 8605 0 0",
                 c, {digit3, digit2, digit1, digit0}, overflow, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_ignored_load();
    test_abort();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
